// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle.
//
// Groups the six raw pushbutton/sensor levels, the six one-cycle event
// pulses and the debounced level vector into one bundle.
//
//   btn_feed_n .. btn_test_n : raw asynchronous levels, 0 = pressed
//   feeding_n .. test_n      : registered one-clk event pulses, 0 = event, idle 1
//   level[5:0]               : debounced levels, 1 = pressed
//                              bit order [5:0] = test, change, heal, echo, light, feed
//
// Modports:
//   slave  : the conditioner (consumes raw buttons, produces pulses/levels)
//   master : whatever drives the buttons and consumes the events
//
// There is no valid/ready handshake on this bundle. The pulse outputs are
// self-timed events: each low cycle is exactly one event, and the consumer
// must sample every cycle (there is no backpressure).

interface button_conditioner_if;

  logic       btn_feed_n;
  logic       btn_light_n;
  logic       btn_echo_n;
  logic       btn_heal_n;
  logic       btn_change_n;
  logic       btn_test_n;

  logic       feeding_n;
  logic       light_out_n;
  logic       echo_sig_n;
  logic       healing_n;
  logic       change_state_n;
  logic       test_n;

  logic [5:0] level;

  modport slave (
    input  btn_feed_n,
    input  btn_light_n,
    input  btn_echo_n,
    input  btn_heal_n,
    input  btn_change_n,
    input  btn_test_n,
    output feeding_n,
    output light_out_n,
    output echo_sig_n,
    output healing_n,
    output change_state_n,
    output test_n,
    output level
  );

  modport master (
    output btn_feed_n,
    output btn_light_n,
    output btn_echo_n,
    output btn_heal_n,
    output btn_change_n,
    output btn_test_n,
    input  feeding_n,
    input  light_out_n,
    input  echo_sig_n,
    input  healing_n,
    input  change_state_n,
    input  test_n,
    input  level
  );

endinterface

// File: rtl/button_conditioner.sv
// Button conditioner for the pet state machine.
//
// Six independent channels (feed, light, echo, heal, change, test). Each raw
// active-low input is synchronized with two flops, then debounced: the
// debounced level ("stable") only moves after the synchronized input has
// disagreed with it for DEB_CYCLES consecutive clocks.
//
// Feed/light/echo/heal/change emit a one-cycle active-low pulse on the
// cycle after their stable level goes released->pressed. The test channel
// instead requires the button to stay pressed for HOLD_CYCLES before it
// emits its pulse; shorter presses are ignored.
//
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous, active-low reset
//   bus : button_conditioner_if.slave (raw buttons in, pulses/levels out)
//
// Parameters:
//   DEB_CYCLES  : consecutive disagreeing cycles before stable changes
//   HOLD_CYCLES : pressed cycles before the test pulse is emitted

module button_conditioner #(
  parameter int DEB_CYCLES  = 1000000,
  parameter int HOLD_CYCLES = 250000000
) (
  input  logic                   clk,
  input  logic                   rst,
  button_conditioner_if.slave    bus
);

  localparam int DW = $clog2(DEB_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;

  // Count value on which the next disagreeing cycle completes the debounce.
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  // Hold counter saturates here; reaching it arms the test pulse.
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

  // Channel order matches level[]: test, change, heal, echo, light, feed.
  logic [5:0] raw_n;
  logic [5:0] sync1_n;
  logic [5:0] sync2_n;
  logic [5:0] stable;    // 1 = pressed
  logic [4:0] pulse_n;   // event pulses for the five simple channels

  assign raw_n = {bus.btn_test_n, bus.btn_change_n, bus.btn_heal_n,
                  bus.btn_echo_n, bus.btn_light_n,  bus.btn_feed_n};

  // Two-flop synchronizer. Reset to the released (high) level so that a
  // button held through reset looks like a fresh press afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_n <= '1;
      sync2_n <= '1;
    end else begin
      sync1_n <= raw_n;
      sync2_n <= sync1_n;
    end
  end

  // Per-channel debounce and edge-to-pulse logic.
  for (genvar g = 0; g < 6; g++) begin : gen_ch
    logic          st;
    logic [DW-1:0] cnt;
    logic          pressed_now;

    assign pressed_now = ~sync2_n[g];

    // Counter runs only while the synchronized input disagrees with the
    // debounced level; any agreeing cycle throws away the partial count,
    // so bounce shorter than DEB_CYCLES never moves stable.
    always_ff @(posedge clk) begin
      if (!rst) begin
        st  <= 1'b0;
        cnt <= '0;
      end else if (pressed_now == st) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        st  <= pressed_now;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign stable[g] = st;

    if (g < 5) begin : gen_edge
      logic st_d;
      logic p_n;

      // Pulse on the rising edge of stable only; releases are silent and a
      // held button cannot retrigger because st_d follows st.
      always_ff @(posedge clk) begin
        if (!rst) begin
          st_d <= 1'b0;
          p_n  <= 1'b1;
        end else begin
          st_d <= st;
          p_n  <= ~(st & ~st_d);
        end
      end

      assign pulse_n[g] = p_n;
    end
  end

  // Test channel: long-press detector on the debounced test level.
  logic [HW-1:0] hold;
  logic          hold_hit;
  logic          hold_hit_d;
  logic          test_p_n;

  // hold_hit marks "counter has reached HOLD_MAX while still pressed"; it
  // stays high for the rest of the press because the counter saturates,
  // so the pulse is taken from its rising edge, giving exactly one pulse
  // per press, one cycle after the reach is registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold       <= '0;
      hold_hit   <= 1'b0;
      hold_hit_d <= 1'b0;
      test_p_n   <= 1'b1;
    end else begin
      if (!stable[5]) begin
        hold <= '0;
      end else if (hold != HOLD_MAX) begin
        hold <= hold + 1'b1;
      end
      hold_hit   <= stable[5] & (hold == HOLD_MAX);
      hold_hit_d <= hold_hit;
      test_p_n   <= ~(hold_hit & ~hold_hit_d);
    end
  end

  assign bus.feeding_n      = pulse_n[0];
  assign bus.light_out_n    = pulse_n[1];
  assign bus.echo_sig_n     = pulse_n[2];
  assign bus.healing_n      = pulse_n[3];
  assign bus.change_state_n = pulse_n[4];
  assign bus.test_n         = test_p_n;

  // stable is already a register, so level adds no latency.
  assign bus.level = stable;

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner with DEB_CYCLES=4, HOLD_CYCLES=20.
//
// Each press that should produce an event pushes {expected cycle, pulse
// mask} onto exp_q when it is driven. A negedge monitor pops one entry for
// every cycle in which any pulse output is low and compares cycle and mask;
// pulses that should not happen find no matching entry, and a missing pulse
// leaves an entry behind for the final empty-queue check.

module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int LAT  = DEB + 3;
  localparam int TLAT = DEB + 3 + HOLD;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_q[$];

  button_conditioner_if bus();

  button_conditioner #(
    .DEB_CYCLES  (DEB),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and edge counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse vector, active high, bit order matches level.
  logic [5:0] pv;
  assign pv = ~{bus.test_n, bus.change_state_n, bus.healing_n,
                bus.echo_sig_n, bus.light_out_n, bus.feeding_n};

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver helpers: advance to #1 after the n-th next rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expect a pulse with the given mask visible after edge cyc+lat.
  task automatic expect_pulse(input int lat, input logic [5:0] mask);
    int t;
    t = cyc + lat;
    exp_q.push_back({t[25:0], mask});
  endtask

  task automatic set_btns(input logic [5:0] pressed);
    {bus.btn_test_n, bus.btn_change_n, bus.btn_heal_n,
     bus.btn_echo_n, bus.btn_light_n, bus.btn_feed_n} = ~pressed;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (pv != 6'b0) begin
      logic [31:0] e;
      int          t;
      t = cyc;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h0;
      check("pulse", {t[25:0], pv}, e);
    end
  end

  initial begin
    logic [5:0] mask;
    int         hold_len;

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    set_btns(6'b0);

    // Reset state.
    tick(3);
    check("rst_level", {26'b0, bus.level}, 32'h0);
    check("rst_out", {26'b0, ~pv}, 32'h3f);
    rst = 1'b1;
    tick(10);

    // Clean feed press, held 30 cycles, silent release.
    set_btns(6'b000001);
    expect_pulse(LAT, 6'b000001);
    tick(10);
    check("feed_level_held", {26'b0, bus.level}, 32'h01);
    tick(20);
    set_btns(6'b0);
    tick(10);
    check("feed_level_rel", {26'b0, bus.level}, 32'h0);

    // Heal bounce: low 2 / high 1 / low 2 / high 3; no event, level stays 0.
    set_btns(6'b001000); tick(2);
    check("heal_b1", {26'b0, bus.level}, 32'h0);
    set_btns(6'b0);      tick(1);
    check("heal_b2", {26'b0, bus.level}, 32'h0);
    set_btns(6'b001000); tick(2);
    check("heal_b3", {26'b0, bus.level}, 32'h0);
    set_btns(6'b0);      tick(3);
    check("heal_b4", {26'b0, bus.level}, 32'h0);
    tick(10);
    check("heal_after", {26'b0, bus.level}, 32'h0);

    // Short test press is ignored.
    set_btns(6'b100000);
    tick(10);
    set_btns(6'b0);
    tick(20);
    check("test_short_level", {26'b0, bus.level}, 32'h0);

    // Long test press emits exactly one pulse.
    set_btns(6'b100000);
    expect_pulse(TLAT, 6'b100000);
    tick(40);
    check("test_long_level", {26'b0, bus.level}, 32'h20);
    set_btns(6'b0);
    tick(15);

    // Feed and change on the same edge.
    set_btns(6'b010001);
    expect_pulse(LAT, 6'b010001);
    tick(12);
    check("dual_level", {26'b0, bus.level}, 32'h11);
    set_btns(6'b0);
    tick(15);

    // Light held through a 2-cycle reset.
    set_btns(6'b000010);
    expect_pulse(LAT, 6'b000010);
    tick(15);
    rst = 1'b0;
    tick(1);
    check("rst1_out", {26'b0, ~pv}, 32'h3f);
    check("rst1_level", {26'b0, bus.level}, 32'h0);
    tick(1);
    check("rst2_out", {26'b0, ~pv}, 32'h3f);
    rst = 1'b1;
    expect_pulse(LAT, 6'b000010);
    tick(15);
    check("light_level", {26'b0, bus.level}, 32'h02);
    set_btns(6'b0);
    tick(15);

    // Echo long hold then re-press after 10 released cycles.
    set_btns(6'b000100);
    expect_pulse(LAT, 6'b000100);
    tick(100);
    set_btns(6'b0);
    tick(10);
    set_btns(6'b000100);
    expect_pulse(LAT, 6'b000100);
    tick(20);
    set_btns(6'b0);
    tick(15);

    // Random clean presses on the simple channels.
    for (int i = 0; i < 8; i++) begin
      mask     = 6'($urandom_range(1, 31));
      hold_len = $urandom_range(8, 20);
      set_btns(mask);
      expect_pulse(LAT, mask);
      tick(hold_len);
      check("rand_level", {26'b0, bus.level}, {26'b0, mask});
      set_btns(6'b0);
      tick(15);
    end

    tick(5);
    check("queue_empty", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
